// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA 640x480@60 timing generator that reads a 320x240 framebuffer with 2x replication
// and aligns the returned pixel with sync/de through a fixed 3-clock pipeline.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [16:0] fb_addr_o,
  output logic        fb_rd_o,
  input  logic [11:0] pix_i,
  input  logic        blank_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [11:0] rgb_o,
  output logic        frame_start_o
);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [9:0]  h_q, v_q, h_d, v_d;
  logic        act_d, hs_d, vs_d, fs_d;
  logic [16:0] addr_d;
  logic        hs1_q, vs1_q, de1_q, fs1_q;
  logic        hs2_q, vs2_q, de2_q, fs2_q;
  always_comb begin
    h_d    = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d    = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    act_d  = (h_q < H_ACT) && (v_q < V_ACT);
    hs_d   = (h_q >= H_SS) && (h_q < H_SE);
    vs_d   = (v_q >= V_SS) && (v_q < V_SE);
    fs_d   = (h_q == 10'd0) && (v_q == 10'd0);
    // y*320 + x as shift-add; halving both counters gives the 2x replication
    addr_d = {v_q[9:1], 8'd0} + {2'd0, v_q[9:1], 6'd0} + {8'd0, h_q[9:1]};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q           <= '0;
      v_q           <= '0;
      fb_addr_o     <= '0;
      fb_rd_o       <= 1'b0;
      {hs1_q, vs1_q, de1_q, fs1_q} <= '0;
      {hs2_q, vs2_q, de2_q, fs2_q} <= '0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      de_o          <= 1'b0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      fb_addr_o     <= act_d ? addr_d : 17'd0;
      fb_rd_o       <= act_d;
      {hs1_q, vs1_q, de1_q, fs1_q} <= {hs_d, vs_d, act_d, fs_d};
      {hs2_q, vs2_q, de2_q, fs2_q} <= {hs1_q, vs1_q, de1_q, fs1_q};
      hsync_o       <= hs2_q ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vs2_q ? SYNC_POL : ~SYNC_POL;
      de_o          <= de2_q;
      rgb_o         <= (de2_q && !blank_i) ? pix_i : 12'd0;
      frame_start_o <= fs2_q;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size instance for line timing/addressing, shrunken instance for whole-frame
// behaviour under random blanking and resets, both against an arithmetic position model.
module tb_vga_timing_gen;
  typedef struct packed {logic de; logic hs; logic vs; logic fs; logic [16:0] addr;} pos_t;
  typedef struct {int h; int v; logic [16:0] addr; logic [11:0] rgb;} vec_t;
  int ca[8] = '{640, 16, 96, 48, 480, 10, 2, 33};
  int cb[8] = '{20, 3, 5, 4, 10, 2, 2, 3};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_rd, a_blank, a_hs, a_vs, a_de, a_fs;
  logic b_rst, b_rd, b_blank, b_hs, b_vs, b_de, b_fs;
  logic [16:0] a_addr, b_addr;
  logic [11:0] a_pix, a_rgb, b_pix, b_rgb;
  int errors = 0, checks = 0;
  int ka = 0, kb = 0;
  logic de_c[3501], hs_c[3501], fs_c[3501];
  logic [11:0] rgb_c[3501];
  logic [16:0] adr_c[3501];
  vga_timing_gen dut_a (
    .clk_i(clk), .rst_i(a_rst), .fb_addr_o(a_addr), .fb_rd_o(a_rd), .pix_i(a_pix),
    .blank_i(a_blank), .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .rgb_o(a_rgb),
    .frame_start_o(a_fs));
  vga_timing_gen #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .fb_addr_o(b_addr), .fb_rd_o(b_rd), .pix_i(b_pix),
    .blank_i(b_blank), .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .rgb_o(b_rgb),
    .frame_start_o(b_fs));
  // framebuffer stand-in: data is the low address bits, one clock of read latency
  always @(posedge clk) begin
    a_pix <= a_addr[11:0];
    b_pix <= b_addr[11:0];
  end
  function automatic pos_t model(input int n, input int c[8]);
    pos_t r;
    int ht, vt, h, v;
    ht = c[0] + c[1] + c[2] + c[3];
    vt = c[4] + c[5] + c[6] + c[7];
    h = n % ht;
    v = (n / ht) % vt;
    r.de = (h < c[0]) && (v < c[4]);
    r.hs = (h >= c[0] + c[1]) && (h < c[0] + c[1] + c[2]);
    r.vs = (v >= c[4] + c[5]) && (v < c[4] + c[5] + c[6]);
    r.fs = (h == 0) && (v == 0);
    r.addr = r.de ? 17'((v / 2) * 320 + h / 2) : 17'd0;
    return r;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", nm, k, act, want);
    end
  endtask
  // k = clocks since the last reset edge; counter position k is live after edge k
  task automatic chk_all(input string t, input int k, input int c[8], input logic blk,
                         input logic [16:0] addr, input logic rd, input logic hs, input logic vs,
                         input logic de, input logic fs, input logic [11:0] rgb);
    pos_t q, p;
    q = (k >= 1) ? model(k - 1, c) : '0;
    p = (k >= 3) ? model(k - 3, c) : '0;
    chk({t, "_addr"}, k, 32'(addr), 32'(q.addr));
    chk({t, "_rd"}, k, 32'(rd), 32'(q.de));
    chk({t, "_hsync"}, k, 32'(hs), 32'(!p.hs));
    chk({t, "_vsync"}, k, 32'(vs), 32'(!p.vs));
    chk({t, "_de"}, k, 32'(de), 32'(p.de));
    chk({t, "_fs"}, k, 32'(fs), 32'(p.fs));
    chk({t, "_rgb"}, k, 32'(rgb), 32'((p.de && !blk) ? p.addr[11:0] : 12'h0));
  endtask
  task automatic step_a();
    logic r;
    r = a_rst;
    @(posedge clk);
    #1;
    ka = r ? 0 : ka + 1;
    chk_all("a", ka, ca, a_blank, a_addr, a_rd, a_hs, a_vs, a_de, a_fs, a_rgb);
    if (ka <= 3500) begin
      de_c[ka] = a_de; hs_c[ka] = a_hs; fs_c[ka] = a_fs; rgb_c[ka] = a_rgb; adr_c[ka] = a_addr;
    end
  endtask
  task automatic step_b();
    logic r;
    r = b_rst;
    @(posedge clk);
    #1;
    kb = r ? 0 : kb + 1;
    chk_all("b", kb, cb, b_blank, b_addr, b_rd, b_hs, b_vs, b_de, b_fs, b_rgb);
  endtask
  initial begin
    vec_t tv[11];
    int fde, run, fhs, hrun, nde, nfs, nz, nde3, nhs3, fs1, fs2, vlow, dcnt;
    tv = '{'{0, 0, 17'd0, 12'h000}, '{1, 0, 17'd0, 12'h000}, '{2, 0, 17'd1, 12'h001},
           '{0, 1, 17'd0, 12'h000}, '{0, 2, 17'd320, 12'h140}, '{639, 0, 17'd319, 12'h13f},
           '{639, 1, 17'd319, 12'h13f}, '{5, 2, 17'd322, 12'h142}, '{638, 2, 17'd639, 12'h27f},
           '{100, 3, 17'd370, 12'h000}, '{700, 2, 17'd0, 12'h000}};
    a_rst = 1'b1; b_rst = 1'b1; a_blank = 1'b0; b_blank = 1'b0;
    repeat (5) step_a();
    a_rst = 1'b0;
    // run to counter position (300,4); output line 3 is blanked
    for (int i = 0; i < 3500; i++) begin
      step_a();
      a_blank = ((ka + 1 - 3) >= 2400) && ((ka + 1 - 3) < 3200);
    end
    fde = 3500; fhs = 3500; nde = 3500; nfs = 0; nz = 0; nde3 = 0; nhs3 = 0; run = 0; hrun = 0;
    for (int k = 0; k <= 3500; k++) begin
      if (de_c[k] && fde == 3500) fde = k;
      if (k >= 3 && !hs_c[k] && fhs == 3500) fhs = k;
      if (k >= 643 && de_c[k] && nde == 3500) nde = k;
      nfs += int'(fs_c[k]);
      if (k >= 2403 && k < 3203) begin
        nde3 += int'(de_c[k]);
        nhs3 += int'(!hs_c[k]);
        nz += int'(rgb_c[k] != 12'h0);
      end
    end
    for (int k = 3; k <= 3500 && de_c[k]; k++) run++;
    for (int k = fhs; k <= 3500 && !hs_c[k]; k++) hrun++;
    chk("first_de_clock", fde, fde, 3);
    chk("first_fs", 3, 32'(fs_c[3]), 1);
    chk("fs_count", 0, nfs, 1);
    chk("de_run_len", 3, run, 640);
    chk("hsync_offset", fhs, fhs - fde, 656);
    chk("hsync_len", fhs, hrun, 96);
    chk("de_period", nde, nde - fde, 800);
    chk("blank_line_de", 2403, nde3, 640);
    chk("blank_line_hsync", 2403, nhs3, 96);
    chk("blank_line_rgb_nonzero", 2403, nz, 0);
    for (int i = 0; i < 11; i++) begin
      int n;
      n = tv[i].v * 800 + tv[i].h;
      chk($sformatf("vec%0d_addr", i), n + 1, 32'(adr_c[n + 1]), 32'(tv[i].addr));
      chk($sformatf("vec%0d_rgb", i), n + 3, 32'(rgb_c[n + 3]), 32'(tv[i].rgb));
    end
    // one-clock reset while the counter sits at (300,4)
    a_rst = 1'b1;
    step_a();
    chk("midrst_de", ka, 32'(a_de), 0);
    chk("midrst_hsync", ka, 32'(a_hs), 1);
    a_rst = 1'b0;
    repeat (3) step_a();
    chk("midrst_fs_after3", ka, 32'(a_fs), 1);
    chk("midrst_de_after3", ka, 32'(a_de), 1);
    repeat (900) step_a();
    repeat (3) step_b();
    b_rst = 1'b0;
    fs1 = -1; fs2 = -1; vlow = 0; dcnt = 0;
    for (int i = 0; i < 6000; i++) begin
      step_b();
      if (i < 1200 && b_fs) begin
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        vlow += int'(!b_vs);
        dcnt += int'(b_de);
      end
      b_blank = 1'($urandom_range(0, 1));
      b_rst = (i > 1200) && ($urandom_range(0, 999) == 0);
    end
    chk("b_fs_period", fs2, fs2 - fs1, 544);
    chk("b_vsync_low_clocks", fs2, vlow, 64);
    chk("b_de_clocks_per_frame", fs2, dcnt, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
